// File: rtl/riscv_memif_pkg.sv
// Shared definitions for the RV12 memory interface: access size codes,
// arbiter state encoding and the alignment rule.
package riscv_memif_pkg;

  localparam logic [1:0] BYTE  = 2'b00;
  localparam logic [1:0] HWORD = 2'b01;
  localparam logic [1:0] WORD  = 2'b10;
  localparam logic [1:0] DWORD = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_DBUSY  = 2'd1,
    ARB_IBUSY  = 2'd2,
    ARB_DMISAL = 2'd3
  } arb_state_e;

  // A dword can never be naturally carried by a 32-bit bus.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] adr,
                                         input int xlen);
    logic mis;
    case (size)
      HWORD:   mis = adr[0];
      WORD:    mis = |adr[1:0];
      DWORD:   mis = (xlen == 64) ? |adr : 1'b1;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/riscv_membus_misalign.sv
// Combinational alignment checker, shared by the data path and any fetch-side user.
module riscv_membus_misalign
  import riscv_memif_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0] size,
  input  logic [2:0] adr,
  output logic       misaligned
);

  assign misaligned = is_misaligned(size, adr, XLEN);

endmodule

// File: rtl/riscv_membus_arb.sv
// Shares one external memory bus between the RV12 fetch and data ports.
//   state  | meaning
//   IDLE   | bus free, arbitrating between pending requests
//   DBUSY  | data access owns the bus until bus_ack/bus_err
//   IBUSY  | fetch owns the bus until bus_ack/bus_err
//   DMISAL | misaligned data access answered locally for one cycle
module riscv_membus_arb
  import riscv_memif_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PLEN       = 32,
  parameter int MAX_DBURST = 4
) (
  input  logic            rstn,
  input  logic            clk,
  input  logic            imem_req,
  input  logic [PLEN-1:0] imem_adr,
  output logic            imem_ack,
  output logic [XLEN-1:0] imem_q,
  output logic            imem_page_fault,
  input  logic            dmem_req,
  input  logic            dmem_we,
  input  logic [1:0]      dmem_size,
  input  logic [PLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  output logic            dmem_ack,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault,
  output logic            bus_req,
  output logic            bus_we,
  output logic [1:0]      bus_size,
  output logic [PLEN-1:0] bus_adr,
  output logic [XLEN-1:0] bus_d,
  input  logic            bus_ack,
  input  logic            bus_err,
  input  logic [XLEN-1:0] bus_q
);

  localparam logic [1:0] S_IDLE   = ARB_IDLE;
  localparam logic [1:0] S_DBUSY  = ARB_DBUSY;
  localparam logic [1:0] S_IBUSY  = ARB_IBUSY;
  localparam logic [1:0] S_DMISAL = ARB_DMISAL;

  localparam int            CW         = $clog2(MAX_DBURST + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_DBURST);
  localparam logic [1:0]    FETCH_SIZE = (XLEN == 64) ? DWORD : WORD;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          dmem_mis;
  logic          bus_done;
  logic          starve;
  logic          grant_mis;
  logic          grant_d;
  logic          grant_i;
  logic          d_done;
  logic          i_done;

  riscv_membus_misalign #(.XLEN(XLEN)) u_misalign (
    .size       (dmem_size),
    .adr        (dmem_adr[2:0]),
    .misaligned (dmem_mis)
  );

  assign bus_done  = bus_ack | bus_err;
  assign starve    = imem_req && (cnt == CNT_MAX);
  assign grant_mis = (state == S_IDLE) && dmem_req && dmem_mis;
  assign grant_d   = (state == S_IDLE) && dmem_req && !dmem_mis && !starve;
  assign grant_i   = (state == S_IDLE) && imem_req && !grant_mis && !grant_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bus_req  <= 1'b0;
      bus_we   <= 1'b0;
      bus_size <= 2'b00;
      bus_adr  <= '0;
      bus_d    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_mis) begin
            state <= S_DMISAL;
          end else if (grant_d) begin
            state    <= S_DBUSY;
            bus_req  <= 1'b1;
            bus_we   <= dmem_we;
            bus_size <= dmem_size;
            bus_adr  <= dmem_adr;
            bus_d    <= dmem_d;
          end else if (grant_i) begin
            state    <= S_IBUSY;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_size <= FETCH_SIZE;
            bus_adr  <= imem_adr;
            bus_d    <= '0;
          end
        end
        S_DBUSY, S_IBUSY: begin
          if (bus_done) begin
            state   <= S_IDLE;
            bus_req <= 1'b0;
          end
        end
        S_DMISAL: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase

      // Misaligned rejections use no bus time and leave the burst count alone.
      if (grant_d) begin
        if (!imem_req)          cnt <= '0;
        else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end else if (grant_i) begin
        cnt <= '0;
      end
    end
  end

  // A requester that already dropped its request gets no ack for the finished cycle.
  assign d_done = (state == S_DBUSY) && bus_done && dmem_req;
  assign i_done = (state == S_IBUSY) && bus_done && imem_req;

  assign imem_ack        = i_done;
  assign imem_q          = i_done ? bus_q : '0;
  assign imem_page_fault = i_done && bus_err;

  assign dmem_ack        = d_done || (state == S_DMISAL);
  assign dmem_q          = d_done ? bus_q : '0;
  assign dmem_misaligned = (state == S_DMISAL);
  assign dmem_page_fault = d_done && bus_err;

endmodule

// File: tb/tb_riscv_membus_arb.sv
// Bench for riscv_membus_arb: directed scenarios plus randomized traffic,
// checked cycle by cycle against a bus-ownership reference model.
module tb_riscv_membus_arb;

  localparam int XLEN = 32;
  localparam int PLEN = 32;
  localparam int MAXB = 4;

  localparam int NONE  = 0;
  localparam int OWN_D = 1;
  localparam int OWN_I = 2;
  localparam int OWN_M = 3;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            imem_req;
  logic [PLEN-1:0] imem_adr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_q;
  logic            imem_page_fault;
  logic            dmem_req;
  logic            dmem_we;
  logic [1:0]      dmem_size;
  logic [PLEN-1:0] dmem_adr;
  logic [XLEN-1:0] dmem_d;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_q;
  logic            dmem_misaligned;
  logic            dmem_page_fault;
  logic            bus_req;
  logic            bus_we;
  logic [1:0]      bus_size;
  logic [PLEN-1:0] bus_adr;
  logic [XLEN-1:0] bus_d;
  logic            bus_ack;
  logic            bus_err;
  logic [XLEN-1:0] bus_q;

  always #5 clk = ~clk;

  riscv_membus_arb #(.XLEN(XLEN), .PLEN(PLEN), .MAX_DBURST(MAXB)) dut (
    .rstn(rstn), .clk(clk),
    .imem_req(imem_req), .imem_adr(imem_adr), .imem_ack(imem_ack), .imem_q(imem_q),
    .imem_page_fault(imem_page_fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size), .dmem_adr(dmem_adr),
    .dmem_d(dmem_d), .dmem_ack(dmem_ack), .dmem_q(dmem_q), .dmem_misaligned(dmem_misaligned),
    .dmem_page_fault(dmem_page_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_size(bus_size), .bus_adr(bus_adr), .bus_d(bus_d),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_q(bus_q)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // requesters
  bit          d_pend, d_we, d_auto, d_acked;
  logic [1:0]  d_size;
  logic [31:0] d_adr, d_d;
  int          d_seq;
  bit          i_pend, i_auto, i_acked;
  logic [31:0] i_adr;
  bit          rnd_req, rnd_slave;

  // slave
  bit          s_active, err_next, fixed_q_en;
  int          s_wait, lat;
  logic [31:0] fixed_q;

  // reference model and observation log
  int          m_own, m_cnt;
  logic        g_we;
  logic [1:0]  g_size;
  logic [31:0] g_adr, g_d;
  logic [31:0] grant_adr[$];
  bit          prev_breq;
  int          n_rise, n_dack, n_iack;
  logic [31:0] last_dq;
  bit          last_dmis, last_ipf;

  function automatic bit ref_mis(input logic [1:0] size, input logic [31:0] adr);
    int unsigned nbytes;
    nbytes = 32'd1 << size;
    if (nbytes * 8 > XLEN) return 1'b1;
    return (adr % nbytes) != 0;
  endfunction

  function automatic int pick(input bit dreq, input bit dmis, input bit ireq, input int cnt);
    if (dreq && dmis) return OWN_M;
    if (dreq && !(ireq && cnt >= MAXB)) return OWN_D;
    if (ireq) return OWN_I;
    return NONE;
  endfunction

  function automatic int dgrants_before(input logic [31:0] fadr);
    int n = 0;
    foreach (grant_adr[k]) begin
      if (grant_adr[k] == fadr) return n;
      n++;
    end
    return -1;
  endfunction

  function automatic logic [31:0] grant_at(input int k);
    return (k < grant_adr.size()) ? grant_adr[k] : 32'hFFFF_FFFF;
  endfunction

  task automatic check_cycle();
    bit done, e_dack, e_iack;
    int w;
    done = bus_ack | bus_err;
    chk("bus_req", bus_req, (m_own == OWN_D) || (m_own == OWN_I));
    if (m_own == OWN_D) begin
      chk("d_bus_we", bus_we, g_we);
      chk("d_bus_size", bus_size, g_size);
      chk("d_bus_adr", bus_adr, g_adr);
      chk("d_bus_d", bus_d, g_d);
    end else if (m_own == OWN_I) begin
      chk("i_bus_we", bus_we, 1'b0);
      chk("i_bus_size", bus_size, 2'b10);
      chk("i_bus_adr", bus_adr, g_adr);
    end
    e_dack = ((m_own == OWN_D) && done && dmem_req) || (m_own == OWN_M);
    e_iack = (m_own == OWN_I) && done && imem_req;
    chk("dmem_ack", dmem_ack, e_dack);
    chk("imem_ack", imem_ack, e_iack);
    if (e_dack) begin
      chk("dmem_misaligned", dmem_misaligned, m_own == OWN_M);
      chk("dmem_page_fault", dmem_page_fault, (m_own == OWN_D) && bus_err);
      if (m_own == OWN_D) chk("dmem_q", dmem_q, bus_q);
    end
    if (e_iack) begin
      chk("imem_page_fault", imem_page_fault, bus_err);
      chk("imem_q", imem_q, bus_q);
    end
    if (dmem_ack) begin
      n_dack++; d_acked = 1; last_dq = dmem_q; last_dmis = dmem_misaligned;
    end
    if (imem_ack) begin
      n_iack++; i_acked = 1; last_ipf = imem_page_fault;
    end
    if (bus_req && !prev_breq) begin
      n_rise++; grant_adr.push_back(bus_adr);
    end
    prev_breq = bus_req;

    // who holds the bus in the next cycle
    if (m_own == OWN_D || m_own == OWN_I) begin
      if (done) m_own = NONE;
    end else if (m_own == OWN_M) begin
      m_own = NONE;
    end else begin
      w = pick(dmem_req, ref_mis(dmem_size, dmem_adr), imem_req, m_cnt);
      if (w == OWN_D) begin
        m_cnt = imem_req ? ((m_cnt < MAXB) ? m_cnt + 1 : MAXB) : 0;
        g_we = dmem_we; g_size = dmem_size; g_adr = dmem_adr; g_d = dmem_d;
      end else if (w == OWN_I) begin
        m_cnt = 0; g_adr = imem_adr;
      end
      m_own = w;
    end
  endtask

  task automatic cycle();
    int r;
    if (rnd_req) begin
      if (!d_pend && $urandom_range(2) == 0) begin
        d_pend = 1; d_we = 1'($urandom_range(1)); d_size = 2'($urandom_range(3));
        d_adr = $urandom; d_d = $urandom;
        if ($urandom_range(3) != 0) d_adr = d_adr & ~((32'd1 << d_size) - 32'd1);
      end
      if (!i_pend && $urandom_range(3) == 0) begin
        i_pend = 1; i_adr = $urandom & ~32'h3;
      end
    end
    if (d_auto && !d_pend) begin
      d_pend = 1; d_we = 0; d_size = 2'b10; d_adr = 32'h1000 + 32'(d_seq * 4); d_d = 0;
      d_seq++;
    end
    if (i_auto && !i_pend) begin
      i_pend = 1; i_adr = 32'h200;
    end
    dmem_req = d_pend; dmem_we = d_we; dmem_size = d_size; dmem_adr = d_adr; dmem_d = d_d;
    imem_req = i_pend; imem_adr = i_adr;

    bus_ack = 0; bus_err = 0;
    if (bus_req) begin
      if (!s_active) begin
        s_active = 1;
        s_wait = rnd_slave ? $urandom_range(2) : lat;
      end
      if (s_wait == 0) begin
        s_active = 0;
        if (err_next) begin
          bus_err = 1; err_next = 0;
        end else if (rnd_slave) begin
          r = $urandom_range(15);
          bus_err = (r < 2);
          bus_ack = (r != 0);
        end else begin
          bus_ack = 1;
        end
        bus_q = fixed_q_en ? fixed_q : $urandom;
      end else begin
        s_wait--;
      end
    end else begin
      s_active = 0;
    end

    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    if (d_acked) begin d_pend = 0; d_acked = 0; end
    if (i_acked) begin i_pend = 0; i_acked = 0; end
  endtask

  task automatic wait_d(input string tag, input int maxc, output int used);
    int s;
    s = n_dack; used = 0;
    while (n_dack == s && used < maxc) begin
      cycle(); used++;
    end
    chk(tag, n_dack != s, 1'b1);
  endtask

  task automatic wait_i(input string tag, input int maxc);
    int s, k;
    s = n_iack; k = 0;
    while (n_iack == s && k < maxc) begin
      cycle(); k++;
    end
    chk(tag, n_iack != s, 1'b1);
  endtask

  task automatic do_reset(input bit with_checks);
    rstn = 0;
    m_own = NONE; m_cnt = 0; s_active = 0; err_next = 0;
    d_pend = 0; i_pend = 0; d_acked = 0; i_acked = 0; d_auto = 0; i_auto = 0;
    dmem_req = 0; imem_req = 0; bus_ack = 0; bus_err = 0; prev_breq = 0;
    #1;
    if (with_checks) begin
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_size", bus_size, 2'b00);
      chk("rst_bus_adr", bus_adr, 32'h0);
      chk("rst_bus_d", bus_d, 32'h0);
      chk("rst_imem_ack", imem_ack, 1'b0);
      chk("rst_dmem_ack", dmem_ack, 1'b0);
      chk("rst_dmem_mis", dmem_misaligned, 1'b0);
      chk("rst_imem_pf", imem_page_fault, 1'b0);
      chk("rst_dmem_pf", dmem_page_fault, 1'b0);
      chk("rst_imem_q", imem_q, 32'h0);
      chk("rst_dmem_q", dmem_q, 32'h0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1;
  endtask

  initial begin
    int used, k;
    d_we = 0; d_size = 0; d_adr = 0; d_d = 0; i_adr = 0; d_seq = 0;
    dmem_we = 0; dmem_size = 0; dmem_adr = 0; dmem_d = 0; imem_adr = 0; bus_q = 0;
    rnd_req = 0; rnd_slave = 0; lat = 0; fixed_q_en = 0; fixed_q = 0;
    n_rise = 0; n_dack = 0; n_iack = 0; last_dq = 0; last_dmis = 0; last_ipf = 0;
    g_we = 0; g_size = 0; g_adr = 0; g_d = 0;
    do_reset(1);

    // lone word load
    fixed_q_en = 1; fixed_q = 32'hDEAD_BEEF; lat = 1;
    grant_adr.delete();
    d_pend = 1; d_we = 0; d_size = 2'b10; d_adr = 32'h104; d_d = 0;
    wait_d("lone_done", 20, used);
    chk("lone_latency", used, 3);
    chk("lone_adr", grant_at(0), 32'h104);
    chk("lone_q", last_dq, 32'hDEAD_BEEF);
    chk("lone_mis", last_dmis, 1'b0);
    cycle();

    // misaligned halfword store never reaches the bus
    k = n_rise;
    d_pend = 1; d_we = 1; d_size = 2'b01; d_adr = 32'h103; d_d = 32'h5555;
    wait_d("mis_done", 6, used);
    chk("mis_latency", used, 2);
    chk("mis_flag", last_dmis, 1'b1);
    cycle(); cycle();
    chk("mis_no_bus", n_rise - k, 0);

    // simultaneous fetch and data: data first, fetch after one idle cycle
    fixed_q_en = 0; lat = 0;
    grant_adr.delete();
    d_pend = 1; d_we = 0; d_size = 2'b10; d_adr = 32'h400;
    i_pend = 1; i_adr = 32'h200;
    wait_i("sim_done", 20);
    chk("sim_first", grant_at(0), 32'h400);
    chk("sim_second", grant_at(1), 32'h200);
    cycle();

    // starvation guard
    do_reset(0);
    lat = 0; d_auto = 1;
    grant_adr.delete();
    i_pend = 1; i_adr = 32'h200;
    wait_i("starve_done", 60);
    chk("starve_dgrants", dgrants_before(32'h200), 4);
    grant_adr.delete();
    i_pend = 1; i_adr = 32'h200;
    wait_i("starve2_done", 60);
    chk("starve2_dgrants", dgrants_before(32'h200), 4);
    d_auto = 0;
    wait_d("starve_drain", 10, used);
    cycle();

    // bus error on fetch, then a clean fetch
    err_next = 1;
    i_pend = 1; i_adr = 32'h300;
    wait_i("ifault_done", 20);
    chk("ifault_pf", last_ipf, 1'b1);
    cycle();
    i_pend = 1; i_adr = 32'h304;
    wait_i("ifault_next_done", 20);
    chk("ifault_next_pf", last_ipf, 1'b0);
    cycle();

    // reset while a data cycle is outstanding
    lat = 6;
    d_pend = 1; d_we = 0; d_size = 2'b10; d_adr = 32'h500;
    k = 0;
    while (!bus_req && k < 10) begin
      cycle(); k++;
    end
    chk("midrst_bus_up", bus_req, 1'b1);
    rstn = 0;
    #1;
    chk("midrst_bus_drop", bus_req, 1'b0);
    chk("midrst_dack", dmem_ack, 1'b0);
    chk("midrst_iack", imem_ack, 1'b0);
    do_reset(0);
    lat = 1; fixed_q_en = 1; fixed_q = 32'h1234_5678;
    d_pend = 1; d_we = 0; d_size = 2'b10; d_adr = 32'h504;
    wait_d("midrst_after_done", 20, used);
    chk("midrst_after_q", last_dq, 32'h1234_5678);
    cycle();

    // randomized traffic
    fixed_q_en = 0; rnd_req = 1; rnd_slave = 1;
    for (int c = 0; c < 2000; c++) cycle();
    rnd_req = 0;
    for (int c = 0; c < 40; c++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_membus_arb.md
Name: riscv_membus_arb

Overview:
Arbiter and sequencer that shares a single external memory bus between the instruction-fetch port and the data-memory port of the RV12 core. Data accesses have priority, with a starvation guard for fetch. The block detects misaligned data accesses locally without issuing a bus cycle. It returns ack/q/misaligned/page_fault to the MEM/WB stage in the form the write-back logic consumes.

Parameters:
XLEN, 32, data width; 32 or 64
PLEN, 32, physical address width
MAX_DBURST, 4, max consecutive data grants while imem_req is pending before fetch is forced

Ports:
rstn  in  1  asynchronous active-low reset
clk  in  1  clock; all state on rising edge
imem_req  in  1  fetch request; held until imem_ack
imem_adr  in  PLEN  fetch address (XLEN/8 aligned)
imem_ack  out  1  fetch complete (one cycle)
imem_q  out  XLEN  fetch data, valid with imem_ack
imem_page_fault  out  1  bus error on fetch, valid with imem_ack
dmem_req  in  1  data request; held with all qualifiers until dmem_ack
dmem_we  in  1  1=store, 0=load
dmem_size  in  2  00 byte, 01 half, 10 word, 11 dword
dmem_adr  in  PLEN  byte address
dmem_d  in  XLEN  store data
dmem_ack  out  1  data access complete (one cycle)
dmem_q  out  XLEN  load data (unshifted bus word), valid with dmem_ack
dmem_misaligned  out  1  misaligned/illegal size, valid with dmem_ack
dmem_page_fault  out  1  bus error on data, valid with dmem_ack
bus_req  out  1  bus request, registered
bus_we  out  1  bus write, registered
bus_size  out  2  bus size, registered
bus_adr  out  PLEN  bus address, registered
bus_d  out  XLEN  bus write data, registered
bus_ack  in  1  bus transfer done
bus_err  in  1  bus transfer error; ends transfer like bus_ack
bus_q  in  XLEN  bus read data, valid with bus_ack

Behaviour:
- One clock (clk); reset asynchronous, active-low (rstn).
- Reset values: state IDLE, burst counter 0. All outputs 0: bus_req, bus_we, bus_size, bus_adr, bus_d, imem_ack, dmem_ack, dmem_misaligned, both page_fault, imem_q, dmem_q.
- States: IDLE, DBUSY, IBUSY, DMISAL.
- Misaligned check (combinational, dmem port):
  - half: adr[0]!=0.
  - word: adr[1:0]!=0.
  - dword: adr[2:0]!=0 when XLEN=64; always misaligned when XLEN=32.
- IDLE, priority order:
  - dmem_req & misaligned -> DMISAL. No bus cycle.
  - dmem_req & ~(imem_req & cnt==MAX_DBURST) -> DBUSY. Register we/size/adr/d onto bus_*; bus_req=1 next cycle.
  - imem_req -> IBUSY. bus_we=0, bus_size=XLEN word size, bus_adr=imem_adr; bus_req=1.
  - Otherwise stay in IDLE.
- DMISAL: dmem_ack=1, dmem_misaligned=1 for exactly one cycle, then IDLE.
- DBUSY/IBUSY:
  - bus_req and qualifiers held stable until bus_ack|bus_err.
  - In that cycle: requester ack=1 combinationally; q=bus_q; page_fault=bus_err; bus_req drops next edge; next state IDLE.
  - If both bus_ack and bus_err are asserted, the access counts as an error.
- Latency: request visible at edge N -> bus_req high after N. Zero-wait-state slave -> ack in cycle N+1. One idle cycle between grants.
- Burst counter:
  - Increments on each data grant while imem_req=1.
  - Clears on a fetch grant, or on any grant with imem_req=0.
  - Saturates at MAX_DBURST.
- Requester dropping req before ack is a protocol violation. The block completes the bus cycle and discards the ack.
- Reset mid-transfer: bus_req drops immediately, state goes to IDLE, and the outstanding bus cycle is abandoned. The slave must tolerate this.
- imem_ack and dmem_ack are never asserted in the same cycle.

Decomposition:
- Shared package riscv_memif_pkg:
  - size encodings (BYTE=2'b00, HWORD, WORD, DWORD)
  - arbiter state enum
  - function is_misaligned(size, adr, xlen)
- Optional sub-module riscv_membus_misalign (combinational checker) for reuse by the fetch path; FSM, counter and registers stay in the top.

Test Plan:
- Lone load: dmem_req, size=10, adr=0x104, bus_ack 2 cycles later with bus_q=0xDEADBEEF -> bus_adr=0x104, bus_we=0; dmem_ack one cycle with dmem_q=0xDEADBEEF, misaligned=0.
- Misaligned store: size=01, adr=0x103 -> bus_req never asserted; dmem_ack=1 and dmem_misaligned=1 the cycle after request; back to IDLE.
- Simultaneous imem_req (adr 0x200) and dmem_req (adr 0x400) -> data granted first; fetch granted after data ack plus one idle cycle; imem_ack returns bus_q of second transfer.
- Starvation: dmem_req held continuously with imem_req, MAX_DBURST=4 -> exactly 4 data grants, then one fetch grant, counter resets.
- Bus error on fetch: bus_err=1 -> imem_ack=1, imem_page_fault=1; next access has page_fault=0.
- Reset asserted in DBUSY while bus_req=1 -> bus_req=0 asynchronously, no acks; after rstn release a new load completes normally.
